// File: rtl/module_ctrl_mult.sv
// Sequencing controller for the keypad -> Booth multiplier -> display path.
// Captures operands on keypad ready edges, starts the multiplier, watches for completion and drives the display value.
module module_ctrl_mult #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        listo_1,
    input  logic        listo,
    input  logic [7:0]  first_num,
    input  logic [7:0]  second_num,
    input  logic        clear,
    input  logic        mul_done,
    input  logic [15:0] mul_result,
    output logic        mul_valid,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    output logic [15:0] disp_num,
    output logic        disp_load,
    output logic        busy,
    output logic        error,
    output logic [2:0]  state
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        OP_A  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        SHOW  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [7:0]       mul_a_r, mul_a_nxt_s;
    logic [7:0]       mul_b_r, mul_b_nxt_s;
    logic [15:0]      disp_num_r, disp_num_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             load_s;
    logic             prev_1_r, prev_2_r;
    logic             rise_1_s, rise_2_s;
    logic             mul_valid_r, disp_load_r, busy_r, error_r;

    assign rise_1_s = listo_1 & ~prev_1_r;
    assign rise_2_s = listo & ~prev_2_r;

    // Next-state and next-register computation; clear overrides all state logic.
    always_comb begin
        state_nxt_s    = state_r;
        mul_a_nxt_s    = mul_a_r;
        mul_b_nxt_s    = mul_b_r;
        disp_num_nxt_s = disp_num_r;
        cnt_nxt_s      = cnt_r;
        load_s         = 1'b0;
        if (clear) begin
            state_nxt_s    = IDLE;
            mul_a_nxt_s    = 8'h00;
            mul_b_nxt_s    = 8'h00;
            disp_num_nxt_s = 16'h0000;
            cnt_nxt_s      = '0;
            load_s         = 1'b1;
        end else begin
            case (state_r)
                IDLE, SHOW, ERR: begin
                    if (rise_1_s) begin
                        mul_a_nxt_s    = first_num;
                        disp_num_nxt_s = {{8{first_num[7]}}, first_num};
                        load_s         = 1'b1;
                        state_nxt_s    = OP_A;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                OP_A: begin
                    // Second operand wins over a simultaneous first-operand edge.
                    if (rise_2_s) begin
                        mul_b_nxt_s    = second_num;
                        disp_num_nxt_s = {{8{second_num[7]}}, second_num};
                        load_s         = 1'b1;
                        state_nxt_s    = START;
                    end else if (rise_1_s) begin
                        mul_a_nxt_s    = first_num;
                        disp_num_nxt_s = {{8{first_num[7]}}, first_num};
                        load_s         = 1'b1;
                    end else begin
                        state_nxt_s = OP_A;
                    end
                end
                START: begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = WAIT;
                end
                WAIT: begin
                    if (mul_done) begin
                        disp_num_nxt_s = mul_result;
                        load_s         = 1'b1;
                        state_nxt_s    = SHOW;
                    end else if (cnt_r == CNT_MAX) begin
                        disp_num_nxt_s = 16'h0000;
                        load_s         = 1'b1;
                        state_nxt_s    = ERR;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt_s    = IDLE;
                    mul_a_nxt_s    = 8'h00;
                    mul_b_nxt_s    = 8'h00;
                    disp_num_nxt_s = 16'h0000;
                    cnt_nxt_s      = '0;
                end
            endcase
        end
    end

    // State, datapath and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            mul_a_r     <= 8'h00;
            mul_b_r     <= 8'h00;
            disp_num_r  <= 16'h0000;
            cnt_r       <= '0;
            prev_1_r    <= 1'b0;
            prev_2_r    <= 1'b0;
            mul_valid_r <= 1'b0;
            disp_load_r <= 1'b0;
            busy_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            mul_a_r     <= mul_a_nxt_s;
            mul_b_r     <= mul_b_nxt_s;
            disp_num_r  <= disp_num_nxt_s;
            cnt_r       <= cnt_nxt_s;
            prev_1_r    <= listo_1;
            prev_2_r    <= listo;
            mul_valid_r <= (state_nxt_s == START);
            disp_load_r <= load_s;
            busy_r      <= (state_nxt_s == START) || (state_nxt_s == WAIT);
            error_r     <= (state_nxt_s == ERR);
        end
    end

    assign mul_valid = mul_valid_r;
    assign mul_a     = mul_a_r;
    assign mul_b     = mul_b_r;
    assign disp_num  = disp_num_r;
    assign disp_load = disp_load_r;
    assign busy      = busy_r;
    assign error     = error_r;
    assign state     = state_r;

endmodule

// File: tb/tb_module_ctrl_mult.sv
// Directed self-checking bench for module_ctrl_mult with hand-computed expectations.
module tb_module_ctrl_mult;

    logic        clk = 1'b0;
    logic        rst, listo_1, listo, clear, mul_done;
    logic [7:0]  first_num, second_num;
    logic [15:0] mul_result;
    logic        mul_valid, disp_load, busy, error;
    logic [7:0]  mul_a, mul_b;
    logic [15:0] disp_num;
    logic [2:0]  state;

    int n_checks = 0;
    int n_errors = 0;
    int valid_cnt = 0;
    int load_cnt = 0;
    logic [7:0] seen_a = 8'h00;
    logic [7:0] seen_b = 8'h00;
    int v0, l0;

    module_ctrl_mult #(.TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .listo_1(listo_1), .listo(listo),
        .first_num(first_num), .second_num(second_num), .clear(clear),
        .mul_done(mul_done), .mul_result(mul_result), .mul_valid(mul_valid),
        .mul_a(mul_a), .mul_b(mul_b), .disp_num(disp_num), .disp_load(disp_load),
        .busy(busy), .error(error), .state(state)
    );

    always #5 clk = ~clk;

    // Pulse counters for mul_valid and disp_load.
    always @(posedge clk) begin
        if (mul_valid) begin
            valid_cnt <= valid_cnt + 1;
            seen_a    <= mul_a;
            seen_b    <= mul_b;
        end
        if (disp_load) load_cnt <= load_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; listo_1 = 1'b0; listo = 1'b0; clear = 1'b0; mul_done = 1'b0;
        first_num = 8'h00; second_num = 8'h00; mul_result = 16'h0000;
        tick(2);
        rst = 1'b0;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_disp", 32'(disp_num), 32'h0);
        chk("rst_outs", {mul_valid, disp_load, busy, error, mul_a, mul_b}, 32'h0);

        // Basic multiply 12 * -3
        v0 = valid_cnt; l0 = load_cnt;
        first_num = 8'h0C; listo_1 = 1'b1; tick();
        chk("a_state", 32'(state), 32'd1);
        chk("a_disp", 32'(disp_num), 32'h000C);
        chk("a_load", 32'(disp_load), 32'd1);
        listo_1 = 1'b0; tick();
        chk("a_load_off", 32'(disp_load), 32'd0);
        second_num = 8'hFD; listo = 1'b1; tick();
        chk("b_state", 32'(state), 32'd2);
        chk("b_disp", 32'(disp_num), 32'hFFFD);
        chk("b_valid", 32'(mul_valid), 32'd1);
        chk("b_busy", 32'(busy), 32'd1);
        listo = 1'b0; tick();
        chk("wait_state", 32'(state), 32'd3);
        chk("valid_off", 32'(mul_valid), 32'd0);
        tick(9);
        mul_done = 1'b1; mul_result = 16'hFFDC; tick();
        mul_done = 1'b0;
        chk("res_state", 32'(state), 32'd4);
        chk("res_disp", 32'(disp_num), 32'hFFDC);
        chk("res_load", 32'(disp_load), 32'd1);
        chk("res_busy", 32'(busy), 32'd0);
        tick();
        chk("basic_valids", 32'(valid_cnt - v0), 32'd1);
        chk("basic_loads", 32'(load_cnt - l0), 32'd3);
        chk("basic_ab", {16'h0, seen_a, seen_b}, 32'h0CFD);

        // Held levels
        v0 = valid_cnt; l0 = load_cnt;
        first_num = 8'h05; listo_1 = 1'b1; tick(20);
        chk("held_opa", 32'(state), 32'd1);
        listo_1 = 1'b0; second_num = 8'h03; listo = 1'b1; tick(20);
        chk("held_wait", 32'(state), 32'd3);
        chk("held_valids", 32'(valid_cnt - v0), 32'd1);
        chk("held_loads", 32'(load_cnt - l0), 32'd2);
        chk("held_ab", {16'h0, seen_a, seen_b}, 32'h0503);
        mul_done = 1'b1; mul_result = 16'h000F; tick();
        mul_done = 1'b0; listo = 1'b0;
        chk("held_show", 32'(disp_num), 32'h000F);

        // Timeout after 64 WAIT cycles
        first_num = 8'h02; listo_1 = 1'b1; tick();
        listo_1 = 1'b0; second_num = 8'h02; listo = 1'b1; tick();
        listo = 1'b0; tick();
        chk("to_wait0", 32'(state), 32'd3);
        tick(63);
        chk("to_wait63", {state, error}, {3'd3, 1'b0});
        tick();
        chk("to_state", 32'(state), 32'd5);
        chk("to_error", 32'(error), 32'd1);
        chk("to_disp", 32'(disp_num), 32'h0);
        first_num = 8'h07; listo_1 = 1'b1; tick();
        listo_1 = 1'b0;
        chk("err_exit", {state, error}, {3'd1, 1'b0});
        chk("err_exit_disp", 32'(disp_num), 32'h0007);

        // Done on the last WAIT cycle: 7 * -2
        second_num = 8'hFE; listo = 1'b1; tick();
        listo = 1'b0; tick(64);
        chk("bd_wait", 32'(state), 32'd3);
        mul_done = 1'b1; mul_result = 16'hFFF2; tick();
        mul_done = 1'b0;
        chk("bd_state", {state, error}, {3'd4, 1'b0});
        chk("bd_disp", 32'(disp_num), 32'hFFF2);

        // Clear during WAIT, late done ignored
        first_num = 8'h81; listo_1 = 1'b1; tick();
        chk("neg_disp", 32'(disp_num), 32'hFF81);
        listo_1 = 1'b0; second_num = 8'h01; listo = 1'b1; tick();
        listo = 1'b0; tick(3);
        clear = 1'b1; tick();
        clear = 1'b0;
        chk("clr_state", 32'(state), 32'd0);
        chk("clr_disp", 32'(disp_num), 32'h0);
        chk("clr_load", 32'(disp_load), 32'd1);
        chk("clr_ab", {16'h0, mul_a, mul_b}, 32'h0);
        mul_done = 1'b1; mul_result = 16'h1234; tick();
        mul_done = 1'b0;
        chk("late_done", 32'(state), 32'd0);
        chk("late_disp", 32'(disp_num), 32'h0);

        // Reset during OP_A
        first_num = 8'h11; listo_1 = 1'b1; tick();
        chk("r_opa", 32'(state), 32'd1);
        listo_1 = 1'b0; rst = 1'b1; tick();
        rst = 1'b0;
        chk("r_state", 32'(state), 32'd0);
        chk("r_outs", {mul_valid, disp_load, busy, error, mul_a, mul_b}, 32'h0);
        chk("r_disp", 32'(disp_num), 32'h0);

        // rise_2 in IDLE is ignored
        v0 = valid_cnt;
        second_num = 8'h22; listo = 1'b1; tick();
        chk("idle_r2", {state, disp_load, mul_b}, {3'd0, 1'b0, 8'h00});
        tick();
        listo = 1'b0;
        chk("idle_novalid", 32'(valid_cnt - v0), 32'd0);

        // Simultaneous edges in OP_A
        first_num = 8'h33; listo_1 = 1'b1; tick();
        listo_1 = 1'b0; tick();
        first_num = 8'h44; second_num = 8'h55; listo_1 = 1'b1; listo = 1'b1; tick();
        chk("sim_state", 32'(state), 32'd2);
        chk("sim_ab", {16'h0, mul_a, mul_b}, 32'h3355);
        chk("sim_disp", 32'(disp_num), 32'h0055);
        listo_1 = 1'b0; listo = 1'b0; tick();
        chk("sim_wait", 32'(state), 32'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/module_ctrl_mult.md
Name: module_ctrl_mult

Overview:
- Sequencing controller for the keypad → Booth multiplier → display path.
- Captures operands on the keypad's ready strobes and launches the multiplier with a one-cycle valid.
- Waits for done with a timeout watchdog, then selects which 16-bit value the BCD/7-segment chain shows.
- Replaces the ad-hoc valid register and priority logic at top level with one explicit FSM, plus clear and error handling.

Parameters:
- TIMEOUT_CYCLES, 64, WAIT cycles allowed for mul_done before declaring error (≥2).
- CNT_W, $clog2(TIMEOUT_CYCLES), width of the watchdog counter (derived, not overridden).

Ports:
- clk  input  1  system clock (divided clock at top level)
- rst  input  1  synchronous, active-high reset
- listo_1  input  1  keypad: first operand complete (level, may stay high)
- listo  input  1  keypad: second operand complete (level, may stay high)
- first_num  input  8  first operand, signed two's complement
- second_num  input  8  second operand, signed two's complement
- clear  input  1  abort/clear request, sampled each cycle
- mul_done  input  1  multiplier result valid
- mul_result  input  16  signed product
- mul_valid  output  1  one-cycle start pulse to multiplier
- mul_a  output  8  registered multiplicand
- mul_b  output  8  registered multiplier
- disp_num  output  16  signed value for BCD converter
- disp_load  output  1  one-cycle pulse when disp_num is updated
- busy  output  1  high in START and WAIT
- error  output  1  high in ERR
- state  output  3  current FSM encoding, for debug

Behaviour:
- Reset is synchronous and active-high: rst sampled high at a clk edge forces state=IDLE and zeroes all registers and outputs, including the edge-detect history and the counter. Every output is 0 after reset.
- Edge detect:
  - rise_1 = listo_1 & ~prev_1; rise_2 = listo & ~prev_2.
  - prev_* are registered every cycle in every state.
  - A level held high produces exactly one event.
- State encodings: IDLE=0, OP_A=1, START=2, WAIT=3, SHOW=4, ERR=5.
- Priority each cycle: rst > clear > state logic.
- clear in any state:
  - state→IDLE; mul_a, mul_b, disp_num→0; counter→0; disp_load=1 for that cycle.
  - A rise seen in the same cycle is discarded.
- IDLE:
  - rise_1: mul_a←first_num; disp_num←sign-extended first_num; disp_load pulse; →OP_A.
  - rise_2 alone is ignored.
- OP_A:
  - rise_1 again: re-latch mul_a and disp_num, pulse disp_load, stay in OP_A.
  - rise_2: mul_b←second_num; disp_num←sign-extended second_num; disp_load pulse; →START.
  - If both rise in the same cycle, rise_2 wins and mul_a is not re-latched.
- START: mul_valid=1 for exactly this one cycle; counter←0; →WAIT.
- WAIT:
  - mul_a and mul_b are stable from START through WAIT.
  - mul_done=1: disp_num←mul_result; disp_load pulse; →SHOW.
  - Otherwise, if counter==TIMEOUT_CYCLES-1: →ERR and disp_num←16'h0000. Else counter++.
  - mul_done on the timeout cycle counts as success.
  - rise_1 and rise_2 are ignored.
- SHOW: holds disp_num. rise_1 behaves as in IDLE (new operation, →OP_A). rise_2 is ignored.
- ERR: error=1 and disp_num=0. rise_1 behaves as in IDLE (error clears on leaving ERR). clear→IDLE.
- mul_done is ignored outside WAIT.
- mul_valid never re-asserts until a new rise_2 arrives in OP_A.
- Latency:
  - Operand capture: disp_num updates at the same clk edge that samples the rising level.
  - mul_valid: asserted the cycle after the rise_2 capture edge.
  - Result: disp_num updates at the edge that samples mul_done=1.
- disp_num is always a 16-bit sign extension of 8-bit operands; there is no saturation.

Test Plan:
- Basic multiply:
  - Stimulus: first_num=8'h0C, raise listo_1; then second_num=8'hFD, raise listo. 10 cycles after mul_valid, assert mul_done with mul_result=16'hFFDC.
  - Response: disp_num sequence 0x000C, 0xFFFD, 0xFFDC. Exactly one mul_valid with mul_a=0x0C, mul_b=0xFD. Three disp_load pulses. Final state=4.
- Held levels: listo_1 and listo held high for 20 cycles each → one capture each and exactly one mul_valid pulse.
- Timeout: mul_done never asserted → error=1 and state=5 exactly 64 WAIT cycles after START. A later rise_1 gives state=1, error=0.
- Done on the boundary: mul_done asserted on the 64th WAIT cycle (counter==63) → state=SHOW, error stays 0, disp_num=mul_result.
- Clear mid-operation: clear pulsed during WAIT → next state=IDLE, disp_num=0, disp_load pulse. A late mul_done is ignored and no SHOW is entered.
- Reset and re-entry:
  - rst held for 1 cycle during OP_A → all outputs 0, state=0.
  - rise_2 in IDLE → no capture and no mul_valid.
  - Simultaneous rise_1/rise_2 in OP_A → mul_b captured and START entered.
